vga_ds_reg_snapshot: RTL and testbench

Register-file snapshot stage between the CPU debug read port and `vga_ds_top`. Once per frame, on the vsync active edge, it scans all 32 CPU registers through the CPU's read port into the back bank of a double-buffered shadow store, then swaps banks. The screen therefore always reads one coherent register set, never a mix of pre- and post-update values. Its screen-side port replaces the direct `regAddr`/`regData` connection to the CPU.

---
 rtl/vga_ds_pkg.sv | 16 +
 rtl/vga_ds_shadow_ram.sv | 41 ++++
 rtl/vga_ds_reg_snapshot.sv | 137 +++++++++++++
 tb/tb_vga_ds_reg_snapshot.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_ds_pkg.sv
// Shared constants and state encoding for the register snapshot stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_ds_pkg;

  localparam int REG_N  = 32;  // CPU registers captured per snapshot
  localparam int REG_AW = 5;   // register address width

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    SWAP
  } snap_state_t;

endpackage

// File: rtl/vga_ds_shadow_ram.sv
// Double-buffered shadow store: 2 banks x 32 words x 32 bits, one write port, one registered read port.
// Latency: 1 cycle read; writes land on the clock edge.
// Backpressure: none; both ports accept every cycle.
//
// Ports:
//   clk, resetn        clock, async active-low reset (read register only)
//   wr_en/addr/data    write port; addr MSB selects the bank
//   rd_addr            read address; addr MSB selects the bank
//   rd_zero            force the registered read data to 0 (no valid snapshot yet)
//   rd_data            registered read data
module vga_ds_shadow_ram
  import vga_ds_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [REG_AW:0]   wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [REG_AW:0]   rd_addr,
  input  logic              rd_zero,
  output logic [31:0]       rd_data
);

  // Contents are deliberately not reset; rd_zero hides them until the first swap.
  logic [31:0] mem [2*REG_N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/vga_ds_reg_snapshot.sv
// Once per frame, scan all 32 CPU registers into the back shadow bank on the vsync active edge, then swap banks.
// Latency: scan busy for 33+RD_LAT cycles; screen read is 1 cycle with no stalls.
// Backpressure: none; vsync edges arriving while busy or frozen are dropped, not queued.
//
// Ports:
//   clk, resetn                  system clock, async active-low reset
//   vsync, freeze                frame edge source; freeze blocks new scans
//   cpu_regAddr / cpu_regData    CPU register-file read port (data RD_LAT cycles after address)
//   scr_regAddr / scr_regData    screen read port, registered
//   busy, frame_cnt              scan in progress; completed snapshots (wraps)
module vga_ds_reg_snapshot
  import vga_ds_pkg::*;
#(
  parameter int RD_LAT    = 1,     // legal 0..3
  parameter bit VSYNC_POL = 1'b0   // vsync active level
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vsync,
  input  logic              freeze,
  output logic [REG_AW-1:0] cpu_regAddr,
  input  logic [31:0]       cpu_regData,
  input  logic [REG_AW-1:0] scr_regAddr,
  output logic [31:0]       scr_regData,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam logic [1:0]        DRAIN_LAST = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);
  localparam logic [REG_AW-1:0] ADDR_LAST  = REG_AW'(REG_N - 1);

  snap_state_t       state, state_nxt;
  logic              vsync_q;
  logic              bank;        // front bank; the back bank is ~bank
  logic              valid;       // at least one snapshot has completed
  logic [1:0]        drain_cnt;
  logic              start;
  logic              scan_act;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;

  assign start = (vsync_q != VSYNC_POL) && (vsync == VSYNC_POL) && !freeze && (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (cpu_regAddr == ADDR_LAST) state_nxt = (RD_LAT == 0) ? SWAP : DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy     = (state != IDLE);
    scan_act = (state == SCAN);
  end

  // Edge detect, address stepping, bank/valid/counter bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_q     <= !VSYNC_POL;
      cpu_regAddr <= '0;
      drain_cnt   <= '0;
      bank        <= 1'b0;
      valid       <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vsync_q <= vsync;
      // Address parks at 0 outside SCAN so the next scan starts at register 0.
      if (scan_act && cpu_regAddr != ADDR_LAST) begin
        cpu_regAddr <= cpu_regAddr + REG_AW'(1);
      end else begin
        cpu_regAddr <= '0;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == SWAP) begin
        bank      <= ~bank;
        valid     <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Capture delay line: aligns each address with the CPU data that returns RD_LAT cycles later.
  generate
    if (RD_LAT == 0) begin : g_nodly
      assign wr_en   = scan_act;
      assign wr_addr = cpu_regAddr;
    end else begin : g_dly
      logic [RD_LAT-1:0] dly_vld;
      logic [REG_AW-1:0] dly_addr [RD_LAT];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          dly_vld <= '0;
          for (int i = 0; i < RD_LAT; i++) dly_addr[i] <= '0;
        end else begin
          dly_vld[0]  <= scan_act;
          dly_addr[0] <= cpu_regAddr;
          for (int i = 1; i < RD_LAT; i++) begin
            dly_vld[i]  <= dly_vld[i-1];
            dly_addr[i] <= dly_addr[i-1];
          end
        end
      end

      assign wr_en   = dly_vld[RD_LAT-1];
      assign wr_addr = dly_addr[RD_LAT-1];
    end
  endgenerate

  // Writes always target the back bank and reads the front bank, so they never collide.
  vga_ds_shadow_ram u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr ({~bank, wr_addr}),
    .wr_data (cpu_regData),
    .rd_addr ({bank, scr_regAddr}),
    .rd_zero (!valid),
    .rd_data (scr_regData)
  );

endmodule

// File: tb/tb_vga_ds_reg_snapshot.sv
// Directed bench for vga_ds_reg_snapshot with RD_LAT=1 and RD_LAT=3 instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_ds_reg_snapshot;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, resetn3, vsync, vsync3, freeze;
  logic [4:0]  scr_addr;
  logic [4:0]  a1, a3;
  logic [31:0] d1, d3, p3_0, p3_1;
  logic [31:0] sd1, sd3;
  logic        busy1, busy3;
  logic [7:0]  fc1, fc3;
  logic        tie0 = 1'b0;

  logic [31:0] rf [32];  // CPU register file model

  // CPU read ports: 1-cycle and 3-cycle latency
  always @(posedge clk) begin
    d1   <= rf[a1];
    p3_0 <= rf[a3];
    p3_1 <= p3_0;
    d3   <= p3_1;
  end

  vga_ds_reg_snapshot #(.RD_LAT(1), .VSYNC_POL(1'b0)) dut1 (
    .clk(clk), .resetn(resetn), .vsync(vsync), .freeze(freeze),
    .cpu_regAddr(a1), .cpu_regData(d1), .scr_regAddr(scr_addr),
    .scr_regData(sd1), .busy(busy1), .frame_cnt(fc1));

  vga_ds_reg_snapshot #(.RD_LAT(3), .VSYNC_POL(1'b0)) dut3 (
    .clk(clk), .resetn(resetn3), .vsync(vsync3), .freeze(tie0),
    .cpu_regAddr(a3), .cpu_regData(d3), .scr_regAddr(scr_addr),
    .scr_regData(sd3), .busy(busy3), .frame_cnt(fc3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  localparam int NT = 8;
  localparam int T_ZERO = 0, T_A5 = 1, T_MIX = 2, T_NEW = 3;
  vec_t tbl [4][NT];

  task automatic run_table(input int which, input int t, input string nm);
    for (int i = 0; i < NT; i++) begin
      @(negedge clk);
      scr_addr = tbl[t][i].addr;
      @(negedge clk);
      chk($sformatf("%s[%0d]", nm, tbl[t][i].addr), (which == 1) ? sd1 : sd3, tbl[t][i].exp);
    end
  endtask

  localparam int LOGN = 60;
  logic        busy_log [LOGN+1];
  logic [31:0] data_log [LOGN+1];
  logic [4:0]  addr_log [LOGN+1];

  // Drives one vsync falling edge (this negedge lies in cycle E); log index j is the negedge in cycle E+j.
  task automatic run_scan(input int which, input bit flip16, input int glitch_at, output int nbusy);
    logic b;
    logic [4:0] a;
    nbusy = 0;
    @(negedge clk);
    if (which == 1) vsync = 1'b0; else vsync3 = 1'b0;
    for (int j = 1; j <= LOGN; j++) begin
      @(negedge clk);
      b = (which == 1) ? busy1 : busy3;
      a = (which == 1) ? a1 : a3;
      busy_log[j] = b;
      addr_log[j] = a;
      data_log[j] = (which == 1) ? sd1 : sd3;
      if (b) nbusy++;
      if (flip16 && a == 5'd16)
        for (int k = 0; k < 32; k++) rf[k] = 32'h1111_0000 + k;
      if (j == glitch_at)     vsync = 1'b1;
      if (j == glitch_at + 1) vsync = 1'b0;
    end
    if (which == 1) vsync = 1'b1; else vsync3 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, fz_busy, found;
    logic [4:0] ta [NT];
    ta = '{5'd0, 5'd1, 5'd7, 5'd15, 5'd16, 5'd20, 5'd30, 5'd31};
    for (int i = 0; i < NT; i++) begin
      tbl[T_ZERO][i] = '{ta[i], 32'h0};
      tbl[T_A5][i]   = '{ta[i], 32'hA5A5_0000 + 32'(ta[i])};
      tbl[T_MIX][i]  = '{ta[i], (ta[i] < 5'd16) ? 32'hA5A5_0000 + 32'(ta[i]) : 32'h1111_0000 + 32'(ta[i])};
      tbl[T_NEW][i]  = '{ta[i], 32'h1111_0000 + 32'(ta[i])};
    end
    for (int k = 0; k < 32; k++) rf[k] = 32'hA5A5_0000 + k;

    resetn = 1'b0; resetn3 = 1'b0; vsync = 1'b1; vsync3 = 1'b1; freeze = 1'b0; scr_addr = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1; resetn3 = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_frame_cnt", 32'(fc1), 32'd0);
    chk("rst_cpu_addr", 32'(a1), 32'd0);
    run_table(1, T_ZERO, "rst_read");

    // First snapshot, RD_LAT=1
    scr_addr = 5'd7;
    run_scan(1, 1'b0, -10, nb);
    chk("scan1_addr_first", 32'(addr_log[1]), 32'd0);
    chk("scan1_addr_last", 32'(addr_log[32]), 32'd31);
    chk("scan1_addr_idle", 32'(addr_log[40]), 32'd0);
    chk("scan1_busy_start", 32'(busy_log[1]), 32'd1);
    chk("scan1_busy_end", 32'(busy_log[34]), 32'd1);
    chk("scan1_busy_after", 32'(busy_log[35]), 32'd0);
    chk("scan1_busy_cycles", 32'(nb), 32'd34);
    chk("scan1_read_in_swap", data_log[35], 32'h0);
    chk("scan1_read_E35", data_log[36], 32'hA5A5_0007);
    chk("scan1_frame_cnt", 32'(fc1), 32'd1);
    run_table(1, T_A5, "scan1_read");

    // Coherence: CPU data changes at address 16 mid-scan
    @(negedge clk);
    scr_addr = 5'd20;
    run_scan(1, 1'b1, -10, nb);
    chk("coh_read_at16", data_log[17], 32'hA5A5_0014);
    chk("coh_read_late", data_log[30], 32'hA5A5_0014);
    chk("coh_read_in_swap", data_log[35], 32'hA5A5_0014);
    chk("coh_read_new", data_log[36], 32'h1111_0014);
    chk("coh_frame_cnt", 32'(fc1), 32'd2);
    run_table(1, T_MIX, "coh_read");

    // Second vsync edge 10 cycles into a scan is dropped
    run_scan(1, 1'b0, 10, nb);
    chk("dbl_busy_cycles", 32'(nb), 32'd34);
    chk("dbl_frame_cnt", 32'(fc1), 32'd3);
    run_table(1, T_NEW, "dbl_read");

    // Freeze: vsync toggling starts nothing
    for (int k = 0; k < 32; k++) rf[k] = 32'h2222_0000 + k;
    freeze = 1'b1;
    fz_busy = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      vsync = ((j / 3) % 2) != 0;
      if (busy1) fz_busy++;
    end
    vsync = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy1) fz_busy++;
    end
    freeze = 1'b0;
    chk("frz_busy_cycles", 32'(fz_busy), 32'd0);
    chk("frz_frame_cnt", 32'(fc1), 32'd3);
    run_table(1, T_NEW, "frz_read");

    // RD_LAT=3: reset asserted at address 20 aborts the scan
    @(negedge clk);
    vsync3 = 1'b0;
    found = 0;
    for (int j = 0; j < 100 && found == 0; j++) begin
      @(negedge clk);
      if (a3 == 5'd20) found = 1;
    end
    chk("rl3_reach_addr20", 32'(found), 32'd1);
    resetn3 = 1'b0;
    #1;
    chk("rl3_rst_busy", 32'(busy3), 32'd0);
    chk("rl3_rst_addr", 32'(a3), 32'd0);
    chk("rl3_rst_frame_cnt", 32'(fc3), 32'd0);
    chk("rl3_rst_read", sd3, 32'h0);
    @(negedge clk);
    vsync3 = 1'b1;
    @(negedge clk);
    resetn3 = 1'b1;
    run_table(3, T_ZERO, "rl3_rst_tbl");
    chk("rl3_idle_after_rst", 32'(busy3), 32'd0);

    scr_addr = 5'd9;
    run_scan(3, 1'b0, -10, nb);
    chk("rl3_busy_cycles", 32'(nb), 32'd36);
    chk("rl3_addr_last", 32'(addr_log[32]), 32'd31);
    chk("rl3_read_in_swap", data_log[37], 32'h0);
    chk("rl3_read_new", data_log[38], 32'h2222_0009);
    chk("rl3_frame_cnt", 32'(fc3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
